// File: rtl/debounced_updown_display.sv
// Two debounced push-buttons step a wrapping hex counter shown on a multiplexed
// common-anode 7-segment display. Define LZ_BLANK_EN to blank leading zero digits.
module debounced_updown_display #(
  parameter int DIGITS     = 8,
  parameter int DB_DEPTH   = 10,
  parameter int SAMPLE_DIV = 100000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_up,
  input  logic                  btn_down,
  output logic [4*DIGITS-1:0]   count,
  output logic [DIGITS-1:0]     anode,
  output logic [7:0]            cathode
);

  localparam int CW = 4 * DIGITS;
  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int KW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SW-1:0]       SAMP_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [KW-1:0]       SCAN_LAST = KW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [CW-1:0]       CNT_ONE   = CW'(1);
  localparam logic [DB_DEPTH-1:0] SH_ONES   = '1;

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  function automatic logic [7:0] digit_seg(input logic [CW-1:0] val, input logic [IW-1:0] idx);
    logic [7:0] seg;
    seg = hex_seg(4'(val >> {idx, 2'b00}));
`ifdef LZ_BLANK_EN
    if ((idx != '0) && ((val >> {idx, 2'b00}) == '0)) seg = 8'hFF;
`endif
    return seg;
  endfunction

  logic                up_sync_p0, up_sync_p1, dn_sync_p0, dn_sync_p1;
  logic [SW-1:0]       samp_cnt;
  logic                strobe;
  logic [DB_DEPTH-1:0] up_sh, dn_sh;
  logic                up_lvl, dn_lvl, up_lvl_p1, dn_lvl_p1;
  logic                up_pulse, dn_pulse;
  logic [KW-1:0]       scan_cnt;
  logic [IW-1:0]       idx, idx_nxt;

  assign strobe   = (samp_cnt == SAMP_LAST);
  assign up_pulse = up_lvl & ~up_lvl_p1;
  assign dn_pulse = dn_lvl & ~dn_lvl_p1;

  // Stage: two-flop synchronisers and shared sample prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_sync_p0 <= 1'b0;
      up_sync_p1 <= 1'b0;
      dn_sync_p0 <= 1'b0;
      dn_sync_p1 <= 1'b0;
      samp_cnt   <= '0;
    end else begin
      up_sync_p0 <= btn_up;
      up_sync_p1 <= up_sync_p0;
      dn_sync_p0 <= btn_down;
      dn_sync_p1 <= dn_sync_p0;
      samp_cnt   <= strobe ? '0 : samp_cnt + SW'(1);
    end
  end

  // Stage: debounce shift registers, debounced levels and edge registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_sh     <= '0;
      dn_sh     <= '0;
      up_lvl    <= 1'b0;
      dn_lvl    <= 1'b0;
      up_lvl_p1 <= 1'b0;
      dn_lvl_p1 <= 1'b0;
    end else begin
      if (strobe) begin
        up_sh <= {up_sh[DB_DEPTH-2:0], up_sync_p1};
        dn_sh <= {dn_sh[DB_DEPTH-2:0], dn_sync_p1};
      end
      if (up_sh == SH_ONES)  up_lvl <= 1'b1;
      else if (up_sh == '0)  up_lvl <= 1'b0;
      if (dn_sh == SH_ONES)  dn_lvl <= 1'b1;
      else if (dn_sh == '0)  dn_lvl <= 1'b0;
      up_lvl_p1 <= up_lvl;
      dn_lvl_p1 <= dn_lvl;
    end
  end

  // Stage: wrapping counter; simultaneous pulses cancel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (up_pulse && !dn_pulse) begin
      count <= count + CNT_ONE;
    end else if (dn_pulse && !up_pulse) begin
      count <= count - CNT_ONE;
    end
  end

  always_comb begin
    idx_nxt = idx;
    if (scan_cnt == SCAN_LAST) idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
  end

  // Stage: digit scan; cathode decodes the index/count of the previous cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      anode    <= ~DIGITS'(1);
      cathode  <= 8'hC0;
    end else begin
      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + KW'(1);
      idx      <= idx_nxt;
      anode    <= ~(DIGITS'(1) << idx_nxt);
      cathode  <= digit_seg(count, idx);
    end
  end

endmodule

// File: tb/tb_debounced_updown_display.sv
// Randomised, self-checking bench for debounced_updown_display (DIGITS=4, DB_DEPTH=4,
// SAMPLE_DIV=2, SCAN_DIV=4) with a run-length behavioural model and literal spot checks.
module tb_debounced_updown_display;

  localparam int D  = 4;
  localparam int DB = 4;
  localparam int SD = 2;
  localparam int SC = 4;

  logic        clk;
  logic        rst;
  logic        btn_up;
  logic        btn_down;
  logic [15:0] count;
  logic [3:0]  anode;
  logic [7:0]  cathode;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  debounced_updown_display #(
    .DIGITS(D), .DB_DEPTH(DB), .SAMPLE_DIV(SD), .SCAN_DIV(SC)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .count(count), .anode(anode), .cathode(cathode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [7:0] exp_seg(input int val, input int i);
    int hi;
    hi = val >> (4 * i);
`ifdef LZ_BLANK_EN
    if (i > 0 && hi == 0) return 8'hFF;
`endif
    return seg_tbl[hi % 16];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: run lengths of equal samples rather than shift registers
  int         m_count, m_idx, m_scan, m_pre;
  int         hi_run [2];
  int         lo_run [2];
  bit         lvl    [2];
  bit         lvl_d  [2];
  bit         q_up [$];
  bit         q_dn [$];
  logic [7:0] m_cath;

  task automatic m_reset();
    m_count = 0; m_idx = 0; m_scan = 0; m_pre = 0; m_cath = 8'hC0;
    for (int b = 0; b < 2; b++) begin
      hi_run[b] = 0; lo_run[b] = DB; lvl[b] = 0; lvl_d[b] = 0;
    end
    q_up = '{1'b0, 1'b0};
    q_dn = '{1'b0, 1'b0};
  endtask

  task automatic m_step();
    bit pu, pd;
    bit smp [2];
    pu = lvl[0] && !lvl_d[0];
    pd = lvl[1] && !lvl_d[1];
    m_cath = exp_seg(m_count, m_idx);
    if (pu && !pd)      m_count = (m_count + 1) % 65536;
    else if (pd && !pu) m_count = (m_count + 65535) % 65536;
    for (int b = 0; b < 2; b++) begin
      lvl_d[b] = lvl[b];
      if (hi_run[b] >= DB)      lvl[b] = 1;
      else if (lo_run[b] >= DB) lvl[b] = 0;
    end
    smp[0] = q_up.pop_front(); q_up.push_back(btn_up);
    smp[1] = q_dn.pop_front(); q_dn.push_back(btn_down);
    if (m_pre == SD - 1) begin
      for (int b = 0; b < 2; b++) begin
        if (smp[b]) begin hi_run[b]++; lo_run[b] = 0; end
        else        begin lo_run[b]++; hi_run[b] = 0; end
      end
    end
    m_pre = (m_pre + 1) % SD;
    if (m_scan == SC - 1) m_idx = (m_idx + 1) % D;
    m_scan = (m_scan + 1) % SC;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else      m_step();
  end

  always @(negedge clk) begin
    logic [3:0] ea;
    if (chk_en) begin
      ea = ~(4'b0001 << m_idx);
      check("count", count, m_count);
      check("anode", anode, ea);
      check("cathode", cathode, m_cath);
    end
  end

  task automatic press(input bit u, input bit d, input int hold);
    @(posedge clk); #2;
    btn_up = u; btn_down = d;
    repeat (hold) @(posedge clk);
    #2;
    btn_up = 0; btn_down = 0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 0;
    #1;
    check("async_rst_count", count, 16'h0000);
    check("async_rst_anode", anode, 4'b1110);
    check("async_rst_cathode", cathode, 8'hC0);
    repeat (3) @(posedge clk);
    #2 rst = 1;
  endtask

  task automatic scan_check(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
    logic [7:0] ec [4];
    logic [3:0] ea;
    int n;
    ec[0] = c0; ec[1] = c1; ec[2] = c2; ec[3] = c3;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      ea = ~(4'b0001 << d);
      n = 0;
      while (anode !== ea && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("scan_anode", anode, ea);
      @(negedge clk);
      check("scan_cathode", cathode, ec[d]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 0; btn_up = 0; btn_down = 0;
    @(posedge clk);
    chk_en = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_count", count, 16'h0000);
    check("rst_anode", anode, 4'b1110);
    check("rst_cathode", cathode, 8'hC0);
    @(posedge clk); #2 rst = 1;

    // Bounce: at most two equal samples per level, then a clean hold
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      btn_up = ((i / 3) % 2 == 0);
    end
    @(posedge clk); #2 btn_up = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bounce_count", count, 16'h0001);
    check("bounce_model", m_count, 16'h0001);
    @(posedge clk); #2 btn_up = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("release_count", count, 16'h0001);

    press(1, 0, 16);
    check("second_up", count, 16'h0002);
    do_reset();

    press(0, 1, 16);
    check("wrap_down", count, 16'hFFFF);
    check("wrap_down_model", m_count, 16'hFFFF);
    press(1, 0, 16);
    check("wrap_up", count, 16'h0000);

    press(1, 0, 16);
    press(1, 1, 16);
    check("simultaneous", count, 16'h0001);
    press(1, 0, 60);
    check("long_hold", count, 16'h0002);

    press(0, 1, 16);
    press(0, 1, 16);
    press(0, 1, 16);
    press(0, 1, 16);
    check("scan_value", count, 16'hFFFE);
    scan_check(8'h86, 8'h8E, 8'h8E, 8'h8E);

    do_reset();
    for (int i = 0; i < 48; i++) press(1, 0, 16);
    check("count_0030", count, 16'h0030);
`ifdef LZ_BLANK_EN
    scan_check(8'hC0, 8'hB0, 8'hFF, 8'hFF);
`else
    scan_check(8'hC0, 8'hB0, 8'hC0, 8'hC0);
`endif
    do_reset();
`ifdef LZ_BLANK_EN
    scan_check(8'hC0, 8'hFF, 8'hFF, 8'hFF);
`else
    scan_check(8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

    // Random bouncing on both buttons, with one asynchronous reset midway
    for (int s = 0; s < 300; s++) begin
      @(posedge clk); #2;
      btn_up   = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) @(posedge clk);
      if (s == 150) begin
        btn_up = 0; btn_down = 0;
        do_reset();
      end
    end
    @(posedge clk); #2 btn_up = 0; btn_down = 0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounced_updown_display.md
# debounced_updown_display

Parametrised successor to the single-button counter display. Two independently debounced push-buttons (up and down) drive a wrapping hex counter of `4*DIGITS` bits. The value is time-multiplexed onto a `DIGITS`-wide common-anode seven-segment display. It sits directly under the board top level, between the raw button pins and the display pins.

## Interface
- `DIGITS`, 8, number of display digits and counter nibbles; legal range 1..8.
- `DB_DEPTH`, 10, consecutive equal samples needed to change a debounced level; minimum 2.
- `SAMPLE_DIV`, 100000, clock cycles per debounce sample strobe; minimum 1.
- `SCAN_DIV`, 50000, clock cycles each digit stays selected; minimum 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous and active-low.
- `btn_up`  in  1  raw, bouncing, asynchronous up button; high = pressed.
- `btn_down`  in  1  raw, bouncing, asynchronous down button; high = pressed.
- `count`  out  4*DIGITS  current counter value.
- `anode`  out  DIGITS  active-low one-hot digit select.
- `cathode`  out  8  active-low segments, ordered {dp,g,f,e,d,c,b,a}.

## Operation
- **Input synchronisation:** each button passes through a 2-flop synchroniser before sampling.
- **Sample strobe:**
  - A shared prescaler counts 0..SAMPLE_DIV-1 and wraps.
  - The strobe is high in the cycle where the prescaler equals SAMPLE_DIV-1.
- **Debounce, per button:**
  - On each strobe, a DB_DEPTH-bit shift register shifts in the synchronised level.
  - The debounced level goes to 1 when the register is all ones.
  - It goes to 0 when the register is all zeros.
  - Otherwise it holds.
- **Edge detect:** a rising edge of a debounced level produces a 1-cycle pulse. Falling edges produce nothing.
- **Counter:**
  - Up pulse alone: +1 modulo 2^(4*DIGITS); all-ones wraps to 0.
  - Down pulse alone: −1 modulo 2^(4*DIGITS); 0 wraps to all-ones.
  - Up and down pulses in the same cycle: count unchanged.
- **Scan:**
  - A scan prescaler counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→…→DIGITS-1→0.
  - `anode[idx]` = 0; all other bits = 1.
- **Segment decode:**
  - `cathode` shows nibble `count[4*idx+3:4*idx]` as hex 0–F, with dp always off.
  - Encodings: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.

## Timing
- **Reset values (while `rst` is low, independent of clk):**
  - `count` = 0.
  - Digit index = 0, so `anode` = ~1 (only bit 0 low).
  - `cathode` = 8'hC0.
  - Both prescalers = 0.
  - Shift registers, debounced levels and edge registers = 0.
  - Synchroniser flops = 0.
- **Reset mid-operation:** any pending pulse is discarded. The first press after release needs the full DB_DEPTH stable samples.
- **Debounce and count latency:** edge E is the clock edge that captures the DB_DEPTH-th consecutive high sample.
  - Debounced level rises at E+1.
  - Pulse is high during the cycle after E+1.
  - `count` updates at E+2.
- **Display:**
  - `anode` and `cathode` are registered.
  - `anode` changes on the edge after the scan prescaler reaches SCAN_DIV-1.
  - `cathode` reflects a new `count` or index exactly 1 cycle after it changes.
- **Bounce filtering:** any low sample inside a run of high samples restarts the run. A level held for fewer than DB_DEPTH strobes never produces a pulse.
- **Press duration:** a held button produces exactly one pulse, with no auto-repeat.
- **DIGITS = 1:** the index is fixed at 0 and `anode` is constant 1'b0.

## Configuration
- **`LZ_BLANK_EN` defined:** leading-zero blanking is on.
  - Digit i (i ≥ 1) drives `cathode` = 8'hFF when every nibble at index ≥ i is zero.
  - Digit 0 is never blanked.
  - Blanking follows `count` with the same 1-cycle latency as decode.
- **`LZ_BLANK_EN` undefined:** all digits always show their hex value, including leading zeros.

## Test plan
All scenarios use DIGITS=4, DB_DEPTH=4, SAMPLE_DIV=2, SCAN_DIV=4.

1. **Reset:** hold `rst` low for 5 cycles.
   - Required: `count`=16'h0000, `anode`=4'b1110, `cathode`=8'hC0.
   - Drive `rst` low asynchronously mid-count: outputs return to these values without a clock edge.
2. **Bounce rejection:** toggle `btn_up` high/low every 3 cycles for 40 cycles, then hold high for 20 cycles.
   - Required: `count` goes 0→1 exactly once.
   - Release and hold low 20 cycles: `count` stays 1.
3. **Wrap:** from reset, one clean `btn_down` press → `count`=16'hFFFF. Then one clean `btn_up` press → 16'h0000.
4. **Simultaneous presses:** `btn_up` and `btn_down` rise on the same cycle and stay high 20 cycles.
   - Required: `count` unchanged; debounced pulses coincide.
5. **Scan:** with `count`=16'h12AF, observe 16 cycles.
   - Required `anode` sequence: 1110, 1101, 1011, 0111, 4 cycles each.
   - Required `cathode` sequence: 8E, 88, A4, F9.
6. **LZ_BLANK_EN:** with `count`=16'h0030, the digit 3 and digit 2 slots show `cathode`=8'hFF, digit 1 shows B0, digit 0 shows C0.
   - With `count`=0, digits 1–3 show FF and digit 0 shows C0.
   - Without the macro, all four digits show C0 for `count`=0.
